// File: rtl/alu_pkg.sv
// Shared ALU opcode and sequencer state definitions for the ALU command
// sequencer and its testbench.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    INC  = 4'd2,
    DEC  = 4'd3,
    CLR  = 4'd4,
    AND  = 4'd5,
    OR   = 4'd6,
    XOR  = 4'd7,
    NOTA = 4'd8,
    NOR  = 4'd9,
    SHL  = 4'd10,
    SHR  = 4'd11,
    ROL  = 4'd12,
    ROR  = 4'd13
  } alu_op_e;

  localparam logic [3:0] OPC_LAST = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  function automatic logic is_illegal(input logic [3:0] opc);
    return opc > OPC_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Command FIFO: registered storage, non-fall-through, wrap-bit pointers.
// An entry pushed on one edge is visible at o_dout and poppable on the next.
module alu_cmd_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [DW-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, pulses alu_set for SET_HOLD cycles, samples the result
// RESP_WAIT cycles later and returns responses in order.
// States: IDLE wait for/pop command | ISSUE alu_set high | WAIT settle | RESP response held
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int SET_HOLD  = 2,
  parameter int RESP_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_overflow,
  output logic             rsp_underflow,
  output logic             rsp_illegal,
  output logic             busy,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_set,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_underflow
);

  localparam int DW    = 4 + 2*WIDTH;
  localparam int MAXC  = (SET_HOLD > RESP_WAIT) ? SET_HOLD : RESP_WAIT;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_alu_opcode;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_set;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_out;
  logic             r_rsp_overflow;
  logic             r_rsp_underflow;
  logic             r_rsp_illegal;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_head;
  logic [3:0]       w_head_opc;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;

  assign w_push = cmd_valid && !w_full;
  assign w_pop  = (r_state == IDLE) && !w_empty;

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ({cmd_opcode, cmd_a, cmd_b}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_head)
  );

  assign w_head_opc = w_head[DW-1 -: 4];
  assign w_head_a   = w_head[2*WIDTH-1 -: WIDTH];
  assign w_head_b   = w_head[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_alu_opcode    <= '0;
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_set       <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_out       <= '0;
      r_rsp_overflow  <= 1'b0;
      r_rsp_underflow <= 1'b0;
      r_rsp_illegal   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            // Illegal opcodes bypass the ALU and answer immediately.
            if (is_illegal(w_head_opc)) begin
              r_rsp_out       <= '0;
              r_rsp_overflow  <= 1'b0;
              r_rsp_underflow <= 1'b0;
              r_rsp_illegal   <= 1'b1;
              r_rsp_valid     <= 1'b1;
              r_state         <= RESP;
            end else begin
              r_alu_opcode <= w_head_opc;
              r_alu_a      <= w_head_a;
              r_alu_b      <= w_head_b;
              r_alu_set    <= 1'b1;
              r_cnt        <= CNT_W'(SET_HOLD - 1);
              r_state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (r_cnt == '0) begin
            r_alu_set <= 1'b0;
            r_cnt     <= CNT_W'(RESP_WAIT - 1);
            r_state   <= WAIT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_out       <= alu_out;
            r_rsp_overflow  <= alu_overflow;
            r_rsp_underflow <= alu_underflow;
            r_rsp_illegal   <= 1'b0;
            r_rsp_valid     <= 1'b1;
            r_state         <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = !w_full;
  assign busy          = (r_state != IDLE) || !w_empty;
  assign alu_opcode    = r_alu_opcode;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_set       = r_alu_set;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_out       = r_rsp_out;
  assign rsp_overflow  = r_rsp_overflow;
  assign rsp_underflow = r_rsp_underflow;
  assign rsp_illegal   = r_rsp_illegal;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_opcode, cmd_a, cmd_b;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_out;
  logic       rsp_overflow, rsp_underflow, rsp_illegal, busy;
  logic [3:0] alu_opcode, alu_a, alu_b;
  logic       alu_set;
  logic [3:0] alu_out;
  logic       alu_overflow, alu_underflow;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .WIDTH(4), .DEPTH(4), .SET_HOLD(2), .RESP_WAIT(1)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_overflow(rsp_overflow),
    .rsp_underflow(rsp_underflow), .rsp_illegal(rsp_illegal),
    .busy(busy),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_set(alu_set),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_underflow(alu_underflow)
  );

  // Behavioural ALU: combinational from the held opcode/A/B pins.
  always_comb begin
    alu_out       = '0;
    alu_overflow  = 1'b0;
    alu_underflow = 1'b0;
    case (alu_op_e'(alu_opcode))
      ADD:  {alu_overflow, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      SUB:  begin alu_out = alu_a - alu_b; alu_underflow = (alu_a < alu_b); end
      INC:  begin alu_out = alu_a + 4'd1; alu_overflow = (alu_a == 4'hf); end
      DEC:  begin alu_out = alu_a - 4'd1; alu_underflow = (alu_a == 4'h0); end
      CLR:  alu_out = 4'h0;
      AND:  alu_out = alu_a & alu_b;
      OR:   alu_out = alu_a | alu_b;
      XOR:  alu_out = alu_a ^ alu_b;
      NOTA: alu_out = ~alu_a;
      NOR:  alu_out = ~(alu_a | alu_b);
      SHL:  begin alu_out = {alu_a[2:0], 1'b0}; alu_overflow = alu_a[3]; end
      SHR:  alu_out = {1'b0, alu_a[3:1]};
      ROL:  alu_out = {alu_a[2:0], alu_a[3]};
      ROR:  alu_out = {alu_a[0], alu_a[3:1]};
      default: ;
    endcase
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int set_hi   = 0;
  int rsp_hi   = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (alu_set)   set_hi <= set_hi + 1;
    if (rsp_valid) rsp_hi <= rsp_hi + 1;
  end

  typedef struct {
    logic [3:0] opc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic       of;
    logic       uf;
    logic       ill;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      output int acc_cyc);
    acc_cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    for (int n = 0; n < 100 && !cmd_ready; n++) @(negedge clk);
    if (!cmd_ready) timeout_fail("push");
    else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push_vec(input int idx);
    int c;
    push(tv[idx].opc, tv[idx].a, tv[idx].b, c);
  endtask

  task automatic get_rsp(input int idx, output int seen_cyc);
    seen_cyc = 0;
    @(negedge clk);
    for (int n = 0; n < 100 && !rsp_valid; n++) @(negedge clk);
    if (!rsp_valid) timeout_fail($sformatf("rsp%0d", idx));
    else begin
      seen_cyc = cyc;
      chk($sformatf("rsp%0d_out", idx), rsp_out,       tv[idx].out);
      chk($sformatf("rsp%0d_of",  idx), rsp_overflow,  tv[idx].of);
      chk($sformatf("rsp%0d_uf",  idx), rsp_underflow, tv[idx].uf);
      chk($sformatf("rsp%0d_ill", idx), rsp_illegal,   tv[idx].ill);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic run_burst(input int first, input int n);
    fork
      begin
        for (int i = 0; i < n; i++) push_vec(first + i);
      end
      begin
        int c;
        for (int i = 0; i < n; i++) get_rsp(first + i, c);
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, cs, s0, k, r0;
    logic acc;

    tv[0]  = '{4'd0,  4'd5,  4'd4,  4'd9,  1'b0, 1'b0, 1'b0}; // ADD 5+4
    tv[1]  = '{4'd1,  4'd5,  4'd6,  4'hf,  1'b0, 1'b1, 1'b0}; // SUB 5-6
    tv[2]  = '{4'd2,  4'd15, 4'd0,  4'h0,  1'b1, 1'b0, 1'b0}; // INC 15
    tv[3]  = '{4'd3,  4'd0,  4'd0,  4'hf,  1'b0, 1'b1, 1'b0}; // DEC 0
    tv[4]  = '{4'd12, 4'hb,  4'd0,  4'h7,  1'b0, 1'b0, 1'b0}; // ROL 1011
    tv[5]  = '{4'd0,  4'd1,  4'd2,  4'd3,  1'b0, 1'b0, 1'b0}; // ADD 1+2
    tv[6]  = '{4'd1,  4'd7,  4'd2,  4'd5,  1'b0, 1'b0, 1'b0}; // SUB 7-2
    tv[7]  = '{4'd7,  4'ha,  4'h6,  4'hc,  1'b0, 1'b0, 1'b0}; // XOR
    tv[8]  = '{4'd6,  4'h8,  4'h1,  4'h9,  1'b0, 1'b0, 1'b0}; // OR
    tv[9]  = '{4'd5,  4'he,  4'h7,  4'h6,  1'b0, 1'b0, 1'b0}; // AND
    tv[10] = '{4'd8,  4'h5,  4'h0,  4'ha,  1'b0, 1'b0, 1'b0}; // NOTA
    tv[11] = '{4'd14, 4'd3,  4'd0,  4'h0,  1'b0, 1'b0, 1'b1}; // illegal

    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_flags", {rsp_overflow, rsp_underflow, rsp_illegal}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_set", alu_set, 0);
    chk("rst_alu_pins", {alu_opcode, alu_a, alu_b}, 0);
    chk("rst_no_set_pulse", set_hi, 0);

    // Single ADD: latency and set-pulse width
    s0 = set_hi;
    push(tv[0].opc, tv[0].a, tv[0].b, c0);
    get_rsp(0, cs);
    chk("add_latency", cs - c0, 4);
    repeat (3) @(negedge clk);
    chk("add_set_cycles", set_hi - s0, 2);
    chk("add_idle_busy", busy, 0);

    // Back-to-back flags test
    run_burst(1, 4);

    // Stalled response: backpressure fills FIFO
    s0 = set_hi;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (k < 6) begin
        cmd_valid = 1'b1; cmd_opcode = tv[5+k].opc; cmd_a = tv[5+k].a; cmd_b = tv[5+k].b;
      end else cmd_valid = 1'b0;
      acc = cmd_ready && (k < 6);
      @(posedge clk);
      if (acc) k++;
    end
    @(negedge clk);
    chk("stall_accepts", k, 5);
    chk("stall_cmd_ready", cmd_ready, 0);
    chk("stall_rsp_valid", rsp_valid, 1);
    chk("stall_busy", busy, 1);
    r0 = set_hi;
    repeat (5) @(negedge clk);
    chk("stall_rsp_out_held", rsp_out, tv[5].out);
    chk("stall_no_set", set_hi - r0, 0);
    chk("stall_total_set", set_hi - s0, 2);
    cmd_valid = 1'b0;
    fork
      push_vec(10);
      begin
        for (int i = 0; i < 6; i++) get_rsp(5 + i, cs);
      end
    join
    repeat (3) @(negedge clk);
    chk("drain_busy", busy, 0);

    // Illegal opcode
    s0 = set_hi;
    push(tv[11].opc, tv[11].a, tv[11].b, c0);
    get_rsp(11, cs);
    chk("ill_latency", cs - c0, 1);
    repeat (3) @(negedge clk);
    chk("ill_no_set", set_hi - s0, 0);

    // Reset during ISSUE
    r0 = rsp_hi;
    push(4'd5, 4'hc, 4'h3, c0);
    @(negedge clk);
    for (int n = 0; n < 20 && !alu_set; n++) @(negedge clk);
    chk("mid_set_before", alu_set, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_set_async", alu_set, 0);
    chk("mid_busy_in_reset", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    r0 = rsp_hi;
    repeat (10) @(negedge clk);
    chk("mid_no_rsp", rsp_hi - r0, 0);
    chk("mid_busy_after", busy, 0);
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_alu_set_after", alu_set, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
